// File: rtl/ebi_pkg.sv
// Shared types and constants for the EBI read responder.
package ebi_pkg;
    typedef enum logic [1:0] {IDLE, STATUS, FETCH, DRIVE} ebi_rd_state_t;

    localparam logic [2:0]  STATUS_BANK = 3'd7;

    localparam logic [2:0]  REG_LINE   = 3'd0;
    localparam logic [2:0]  REG_VBLANK = 3'd1;
    localparam logic [2:0]  REG_FRAME  = 3'd2;
    localparam logic [2:0]  REG_FLAGS  = 3'd3;
    localparam logic [2:0]  REG_ID     = 3'd4;

    localparam logic [15:0] EBI_ID = 16'h4D4E;
endpackage

// File: rtl/ebi_sync.sv
// Two-flop synchroniser for asynchronous EBI inputs, with a configurable reset value.
module ebi_sync #(
    parameter int              WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/ebi_read_responder.sv
// Serves MCU read cycles on the multiplexed EBI bus in the pixel clock domain.
// Bank 7 reads come from local status registers; other banks go to the memory read port.
module ebi_read_responder
    import ebi_pkg::*;
#(
    parameter int          MAX_WAIT     = 8,
    parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD,
    parameter int          CORDW        = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      ebi_ad_in,
    input  logic             ebi_ale,
    input  logic             ebi_re,
    input  logic [2:0]       bank_select,
    output logic [15:0]      ebi_ad_out,
    output logic             ebi_ad_oe,
    input  logic [CORDW-1:0] sy,
    input  logic             vblank,
    input  logic             frame_tick,
    output logic             mem_rd_req,
    output logic [2:0]       mem_rd_bank,
    output logic [14:0]      mem_rd_addr,
    input  logic [15:0]      mem_rd_data,
    input  logic             mem_rd_valid,
    output logic             busy
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [1:0]  w_ctl_s;
    logic [18:0] w_dat_s;
    logic        w_ale_s, w_re_s;
    logic        w_ale_fall, w_re_fall, w_re_rise, w_abort;
    logic        w_unused_ad15;
    logic        r_ale_d, r_re_d;
    logic [14:0] r_addr;
    logic [2:0]  r_bank;

    ebi_rd_state_t     r_state, w_state_nxt;
    logic [WAIT_W-1:0] r_wait, w_wait_nxt;
    logic [15:0]       r_ad_out, w_ad_nxt;
    logic              r_oe, w_oe_nxt;
    logic              r_req, w_req_nxt;
    logic [2:0]        r_rd_bank;
    logic [14:0]       r_rd_addr;

    logic [15:0] r_frame_count;
    logic        r_vblank_d, r_vblank_seen, r_late_read;
    logic        w_flags_clr, w_late_set;
    logic [15:0] w_status_data;

    // RE idles high, so its synchroniser resets high to avoid a false read start.
    ebi_sync #(.WIDTH(2), .RST_VAL(2'b01)) u_sync_ctl (
        .clk   (clk),
        .reset (reset),
        .i_d   ({ebi_ale, ebi_re}),
        .o_q   (w_ctl_s)
    );

    ebi_sync #(.WIDTH(19), .RST_VAL(19'd0)) u_sync_dat (
        .clk   (clk),
        .reset (reset),
        .i_d   ({bank_select, ebi_ad_in}),
        .o_q   (w_dat_s)
    );

    assign w_ale_s       = w_ctl_s[1];
    assign w_re_s        = w_ctl_s[0];
    assign w_unused_ad15 = w_dat_s[15];
    assign w_ale_fall    = r_ale_d & ~w_ale_s;
    assign w_re_fall     = r_re_d & ~w_re_s;
    assign w_re_rise     = ~r_re_d & w_re_s;
    assign w_abort       = w_re_rise | w_ale_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ale_d <= 1'b0;
            r_re_d  <= 1'b1;
            r_addr  <= '0;
            r_bank  <= '0;
        end else begin
            r_ale_d <= w_ale_s;
            r_re_d  <= w_re_s;
            if (w_ale_fall) begin
                r_addr <= w_dat_s[14:0];
                r_bank <= w_dat_s[18:16];
            end
        end
    end

    always_comb begin
        w_status_data = 16'h0000;
        case (r_addr[2:0])
            REG_LINE:   w_status_data = 16'(sy);
            REG_VBLANK: w_status_data = {15'b0, vblank};
            REG_FRAME:  w_status_data = r_frame_count;
            REG_FLAGS:  w_status_data = {14'b0, r_late_read, r_vblank_seen};
            REG_ID:     w_status_data = EBI_ID;
            default:    w_status_data = 16'h0000;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_ad_nxt    = r_ad_out;
        w_oe_nxt    = r_oe;
        w_req_nxt   = 1'b0;
        w_flags_clr = 1'b0;
        w_late_set  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_re_fall) begin
                    if (r_bank == STATUS_BANK) begin
                        w_state_nxt = STATUS;
                    end else begin
                        w_req_nxt   = 1'b1;
                        w_wait_nxt  = '0;
                        w_state_nxt = FETCH;
                    end
                end
            end
            STATUS: begin
                if (w_abort) begin
                    w_oe_nxt    = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_ad_nxt    = w_status_data;
                    w_oe_nxt    = 1'b1;
                    w_flags_clr = (r_addr[2:0] == REG_FLAGS);
                    w_state_nxt = DRIVE;
                end
            end
            FETCH: begin
                if (w_abort) begin
                    w_oe_nxt    = 1'b0;
                    w_state_nxt = IDLE;
                end else if (mem_rd_valid) begin
                    w_ad_nxt    = mem_rd_data;
                    w_oe_nxt    = 1'b1;
                    w_state_nxt = DRIVE;
                end else if (r_wait == WAIT_W'(MAX_WAIT)) begin
                    w_ad_nxt    = TIMEOUT_DATA;
                    w_oe_nxt    = 1'b1;
                    w_late_set  = 1'b1;
                    w_state_nxt = DRIVE;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            DRIVE: begin
                if (w_re_rise) begin
                    w_oe_nxt    = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_oe_nxt    = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_wait    <= '0;
            r_ad_out  <= '0;
            r_oe      <= 1'b0;
            r_req     <= 1'b0;
            r_rd_bank <= '0;
            r_rd_addr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wait   <= w_wait_nxt;
            r_ad_out <= w_ad_nxt;
            r_oe     <= w_oe_nxt;
            r_req    <= w_req_nxt;
            if (w_req_nxt) begin
                r_rd_bank <= r_bank;
                r_rd_addr <= r_addr;
            end
        end
    end

    // Set events take priority over the clear caused by reading the flags register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_count <= '0;
            r_vblank_d    <= 1'b0;
            r_vblank_seen <= 1'b0;
            r_late_read   <= 1'b0;
        end else begin
            r_vblank_d <= vblank;
            if (frame_tick)
                r_frame_count <= r_frame_count + 16'd1;
            if (vblank && !r_vblank_d)
                r_vblank_seen <= 1'b1;
            else if (w_flags_clr)
                r_vblank_seen <= 1'b0;
            if (w_late_set)
                r_late_read <= 1'b1;
            else if (w_flags_clr)
                r_late_read <= 1'b0;
        end
    end

    assign ebi_ad_out  = r_ad_out;
    assign ebi_ad_oe   = r_oe;
    assign mem_rd_req  = r_req;
    assign mem_rd_bank = r_rd_bank;
    assign mem_rd_addr = r_rd_addr;
    assign busy        = (r_state != IDLE);
endmodule

// File: tb/tb_ebi_read_responder.sv
// Bench for ebi_read_responder: directed bus cycles plus randomized reads against a
// transaction-level model of the status registers and a behavioural memory.
module tb_ebi_read_responder;
    localparam int MAX_WAIT = 8;
    localparam int CORDW    = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ebi_ad_in = '0;
    logic        ebi_ale = 1'b0;
    logic        ebi_re = 1'b1;
    logic [2:0]  bank_select = '0;
    logic [15:0] ebi_ad_out;
    logic        ebi_ad_oe;
    logic [CORDW-1:0] sy = '0;
    logic        vblank = 1'b0;
    logic        frame_tick = 1'b0;
    logic        mem_rd_req;
    logic [2:0]  mem_rd_bank;
    logic [14:0] mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        mem_rd_valid;
    logic        busy;

    always #5 clk = ~clk;

    ebi_read_responder #(
        .MAX_WAIT     (MAX_WAIT),
        .TIMEOUT_DATA (16'hDEAD),
        .CORDW        (CORDW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ebi_ad_in    (ebi_ad_in),
        .ebi_ale      (ebi_ale),
        .ebi_re       (ebi_re),
        .bank_select  (bank_select),
        .ebi_ad_out   (ebi_ad_out),
        .ebi_ad_oe    (ebi_ad_oe),
        .sy           (sy),
        .vblank       (vblank),
        .frame_tick   (frame_tick),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_bank  (mem_rd_bank),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: frame counter and sticky flags as the spec defines them.
    int          frame_m = 0;
    bit          vseen_m = 0;
    bit          late_m  = 0;
    logic [15:0] exp_data = '0;
    int          oe_mode = 0;    // 0: oe must be low, 1: must be high, 2: in transition
    bit          req_ok = 0;
    logic [2:0]  exp_bank = '0;
    logic [14:0] exp_addr = '0;
    int          req_cnt = 0;
    int          mem_delay = -1; // -1: memory never answers
    bit          use_fixed = 0;
    logic [15:0] fixed_data = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_range(input string nm, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    function automatic logic [15:0] mem_fn(input logic [2:0] b, input logic [14:0] a);
        return {a[7:0], a[14:7]} ^ {b, 13'h0} ^ 16'h3C5A;
    endfunction

    function automatic logic [15:0] status_model(input int idx);
        case (idx)
            0:       return 16'(sy);
            1:       return {15'b0, vblank};
            2:       return frame_m[15:0];
            3:       return {14'b0, late_m, vseen_m};
            4:       return 16'h4D4E;
            default: return 16'h0000;
        endcase
    endfunction

    // Per-cycle compare of bus and request outputs against the transaction model.
    always @(negedge clk) begin
        if (!reset) begin
            if (oe_mode == 0) check("oe_low", ebi_ad_oe, 1'b0);
            else if (oe_mode == 1) check("oe_high", ebi_ad_oe, 1'b1);
            if (ebi_ad_oe === 1'b1) check("ad_out", ebi_ad_out, exp_data);
            if (mem_rd_req === 1'b1) begin
                req_cnt++;
                check("req_expected", {31'b0, req_ok}, 1);
                check("req_bank", mem_rd_bank, exp_bank);
                check("req_addr", mem_rd_addr, exp_addr);
            end
        end
    end

    // Memory: answers a request after mem_delay cycles, garbage on the data bus otherwise.
    initial begin
        logic [2:0]  rb;
        logic [14:0] ra;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        forever begin
            @(negedge clk);
            mem_rd_valid = 1'b0;
            mem_rd_data  = 16'($urandom);
            if (mem_rd_req === 1'b1 && mem_delay >= 0) begin
                rb = mem_rd_bank;
                ra = mem_rd_addr;
                repeat (mem_delay) begin
                    @(negedge clk);
                    mem_rd_data = 16'($urandom);
                end
                mem_rd_valid = 1'b1;
                mem_rd_data  = use_fixed ? fixed_data : mem_fn(rb, ra);
            end
        end
    end

    task automatic ale_phase(input logic [2:0] b, input logic [15:0] a);
        @(negedge clk);
        ebi_ad_in   = a;
        bank_select = b;
        ebi_ale     = 1'b1;
        repeat (3) @(negedge clk);
        ebi_ale = 1'b0;
        repeat (4) @(negedge clk);
        ebi_ad_in   = 16'($urandom);
        bank_select = 3'($urandom);
    endtask

    task automatic do_read(input logic [2:0] b, input logic [15:0] a, input logic [15:0] expd,
                           input int dly, input int lo, input int hi, input string nm);
        int cnt;
        int rc0;
        ale_phase(b, a);
        exp_data  = expd;
        exp_bank  = b;
        exp_addr  = a[14:0];
        mem_delay = dly;
        req_ok    = (b != 3'd7);
        rc0       = req_cnt;
        oe_mode   = 2;
        ebi_re    = 1'b0;
        cnt       = 0;
        while (ebi_ad_oe !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check_range({nm, "_oe_rise"}, cnt, lo, hi);
        if (ebi_ad_oe === 1'b1) begin
            oe_mode = 1;
            repeat (3) @(negedge clk);
            check({nm, "_data"}, ebi_ad_out, expd);
        end
        ebi_re  = 1'b1;
        oe_mode = 2;
        cnt     = 0;
        while (ebi_ad_oe !== 1'b0 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check_range({nm, "_oe_fall"}, cnt, 0, 4);
        oe_mode   = 0;
        req_ok    = 0;
        mem_delay = -1;
        repeat (3) @(negedge clk);
        check({nm, "_reqs"}, req_cnt - rc0, (b != 3'd7) ? 1 : 0);
        check({nm, "_busy"}, busy, 1'b0);
    endtask

    task automatic idle_activity();
        int   n;
        logic nv;
        n = $urandom_range(3, 12);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_tick = ($urandom_range(0, 3) == 0);
            if (frame_tick) frame_m = (frame_m + 1) % 65536;
            nv = ($urandom_range(0, 4) == 0) ? ~vblank : vblank;
            if (nv && !vblank) vseen_m = 1;
            vblank = nv;
            sy = CORDW'($urandom);
        end
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int          cnt, rc0, k, idx, d;
        logic [15:0] a, e;
        logic [2:0]  b;

        repeat (3) @(negedge clk);
        check("rst_ad_out", ebi_ad_out, 16'h0000);
        check("rst_oe", ebi_ad_oe, 1'b0);
        check("rst_req", mem_rd_req, 1'b0);
        check("rst_bank", mem_rd_bank, 3'd0);
        check("rst_addr", mem_rd_addr, 15'd0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        sy = 10'd345;
        do_read(3'd7, 16'h0000, 16'h0159, 0, 3, 4, "status_line");

        use_fixed  = 1;
        fixed_data = 16'hBEEF;
        do_read(3'd2, 16'h0123, 16'hBEEF, 3, 3, 7, "mem_read");
        use_fixed  = 0;

        do_read(3'd1, 16'h8042, 16'hDEAD, -1, 3 + MAX_WAIT, 5 + MAX_WAIT, "timeout");
        do_read(3'd7, 16'h0003, 16'h0002, 0, 3, 4, "flags_after_timeout");
        do_read(3'd7, 16'h7FF3, 16'h0000, 0, 3, 4, "flags_cleared");
        late_m  = 0;
        vseen_m = 0;

        @(negedge clk);
        frame_tick = 1'b1;
        repeat (65537) @(negedge clk);
        frame_tick = 1'b0;
        frame_m = (frame_m + 65537) % 65536;
        repeat (2) @(negedge clk);
        do_read(3'd7, 16'h0002, 16'h0001, 0, 3, 4, "frame_wrap");
        do_read(3'd7, 16'h0004, 16'h4D4E, 0, 3, 4, "id_reg");

        // Abort: RE released one cycle after the request; the memory answers too late.
        ale_phase(3'd3, 16'h0456);
        exp_bank  = 3'd3;
        exp_addr  = 15'h0456;
        req_ok    = 1;
        mem_delay = 6;
        rc0       = req_cnt;
        oe_mode   = 0;
        ebi_re    = 1'b0;
        cnt       = 0;
        while (mem_rd_req !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check_range("abort_req_lat", cnt, 3, 4);
        @(negedge clk);
        ebi_re = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_reqs", req_cnt - rc0, 1);
        check("abort_busy", busy, 1'b0);
        req_ok    = 0;
        mem_delay = -1;
        do_read(3'd4, 16'h0789, mem_fn(3'd4, 15'h0789), 2, 3, 6, "after_abort");

        for (int t = 0; t < 40; t++) begin
            idle_activity();
            k = $urandom_range(0, 9);
            a = 16'($urandom);
            if (k <= 4) begin
                idx = (k == 0) ? 3 : $urandom_range(0, 7);
                a[2:0] = 3'(idx);
                e = status_model(idx);
                if (idx == 3) begin
                    late_m  = 0;
                    vseen_m = 0;
                end
                do_read(3'd7, a, e, 0, 3, 4, "rnd_status");
            end else if (k <= 8) begin
                b = 3'($urandom_range(0, 6));
                d = $urandom_range(0, 7);
                do_read(b, a, mem_fn(b, a[14:0]), d, 3, 4 + d, "rnd_mem");
            end else begin
                b = 3'($urandom_range(0, 6));
                do_read(b, a, 16'hDEAD, -1, 3 + MAX_WAIT, 5 + MAX_WAIT, "rnd_timeout");
                late_m = 1;
            end
        end

        // Reset while driving the bus; a pending late_read flag must be cleared.
        @(negedge clk);
        vblank = 1'b0;
        do_read(3'd5, 16'h0111, 16'hDEAD, -1, 3 + MAX_WAIT, 5 + MAX_WAIT, "pre_reset_timeout");
        ale_phase(3'd7, 16'h0004);
        exp_data = 16'h4D4E;
        oe_mode  = 2;
        ebi_re   = 1'b0;
        cnt      = 0;
        while (ebi_ad_oe !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check_range("drive_before_reset", cnt, 3, 4);
        oe_mode = 1;
        repeat (2) @(negedge clk);
        oe_mode = 2;
        reset   = 1'b1;
        @(negedge clk);
        check("reset_oe", ebi_ad_oe, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_req", mem_rd_req, 1'b0);
        ebi_re = 1'b1;
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        oe_mode = 0;
        frame_m = 0;
        late_m  = 0;
        vseen_m = 0;
        repeat (4) @(negedge clk);
        do_read(3'd7, 16'h0003, 16'h0000, 0, 3, 4, "flags_after_reset");
        do_read(3'd7, 16'h0002, 16'h0000, 0, 3, 4, "frame_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
